exc_sequencer: RTL

Sequences exceptions and interrupts for the five-stage MIPS pipeline, sitting beside the decode-stage control unit. It latches peripheral interrupt requests and picks one event per cycle: an undefined instruction or a pending interrupt. At the decode stage it squashes the faulting or interrupted instruction, redirects fetch to the kernel vector and captures EPC and cause. It tracks kernel mode and sequences the return from the handler.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/exc_sequencer_if.sv | 30 +++
 rtl/irq_pend_latch.sv | 52 +++++
 rtl/exc_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared constants, cause encodings and state type for the exception sequencer
package exc_pkg;

    localparam int NIRQ = 4;

    localparam logic [31:0] EXC_VEC_IRQ   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_UNDEF = 32'h8000_0008;

    localparam logic [2:0] CAUSE_UNDEF = 3'b100;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_KERNEL,
        ST_RETURN,
        ST_HALT
    } exc_state_t;

    function automatic logic [2:0] irq_cause(input logic [1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// rtl/exc_sequencer_if.sv - decode-stage control and redirect bundle between pipeline and sequencer
interface exc_sequencer_if;
    import exc_pkg::*;

    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_undef;
    logic        id_eret;
    logic        stall;
    logic        ex_redirect;

    logic        exc_take;
    logic [31:0] exc_vector;
    logic        eret_take;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        ker;
    logic        halt;

    modport master (
        output id_valid, id_pc, id_undef, id_eret, stall, ex_redirect,
        input  exc_take, exc_vector, eret_take, epc, cause, ker, halt
    );

    modport slave (
        input  id_valid, id_pc, id_undef, id_eret, stall, ex_redirect,
        output exc_take, exc_vector, eret_take, epc, cause, ker, halt
    );

endinterface

// File: rtl/irq_pend_latch.sv
// rtl/irq_pend_latch.sv - IRQ edge detect, pending bits with per-line clear, fixed-priority pick
module irq_pend_latch
    import exc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_line,
    input  logic [NIRQ-1:0] mask,
    input  logic            clr_en,
    input  logic [1:0]      clr_idx,
    output logic [NIRQ-1:0] pend,
    output logic            req_valid,
    output logic [1:0]      req_idx
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] clr_vec;
    logic [NIRQ-1:0] elig;

    always_comb begin
        rise    = irq_line & ~irq_q;
        clr_vec = '0;
        if (clr_en) begin
            clr_vec[clr_idx] = 1'b1;
        end
        elig = pend & mask;
    end

    // A fresh edge on the line being cleared wins, so the request is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= '0;
            pend  <= '0;
        end else begin
            irq_q <= irq_line;
            pend  <= (pend & ~clr_vec) | rise;
        end
    end

    always_comb begin
        req_valid = 1'b0;
        req_idx   = 2'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                req_valid = 1'b1;
                req_idx   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - exception/interrupt sequencer for the decode stage; EXC_IRQ_MASK_EN enables the IRQ mask register
module exc_sequencer
    import exc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NIRQ-1:0]       irq_line,
    input  logic                  mask_we,
    input  logic [NIRQ-1:0]       mask_wdata,
    exc_sequencer_if.slave        bus
);

    exc_state_t      state;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] pend;
    logic            req_valid;
    logic [1:0]      req_idx;
    logic            gate;
    logic            take_undef;
    logic            take_irq;
    logic            exc_take;
    logic            eret_take;
    logic            halt_go;
    logic [31:0]     epc_q;
    logic [2:0]      cause_q;
    logic            ker_q;
    logic            halt_q;

`ifdef EXC_IRQ_MASK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask <= 4'hF;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
`else
    logic unused_mask;
    assign mask        = 4'hF;
    assign unused_mask = ^{mask_we, mask_wdata};
`endif

    irq_pend_latch u_pend (
        .clk       (clk),
        .reset     (reset),
        .irq_line  (irq_line),
        .mask      (mask),
        .clr_en    (take_irq),
        .clr_idx   (req_idx),
        .pend      (pend),
        .req_valid (req_valid),
        .req_idx   (req_idx)
    );

    always_comb begin
        gate       = bus.id_valid & ~bus.stall & ~bus.ex_redirect;
        take_undef = (state == ST_RUN) & gate & bus.id_undef;
        take_irq   = (state == ST_RUN) & gate & ~bus.id_undef & req_valid;
        exc_take   = take_undef | take_irq;
        halt_go    = (state == ST_KERNEL) & gate & bus.id_undef;
        eret_take  = (state == ST_KERNEL) & gate & bus.id_eret & ~bus.id_undef;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_RUN;
            epc_q   <= '0;
            cause_q <= '0;
            ker_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_take) begin
                        epc_q   <= bus.id_pc;
                        cause_q <= take_undef ? CAUSE_UNDEF : irq_cause(req_idx);
                        ker_q   <= 1'b1;
                        state   <= ST_KERNEL;
                    end
                end
                ST_KERNEL: begin
                    if (halt_go) begin
                        halt_q <= 1'b1;
                        state  <= ST_HALT;
                    end else if (eret_take) begin
                        ker_q <= 1'b0;
                        state <= ST_RETURN;
                    end
                end
                // One dead cycle so the returning instruction reaches ID first.
                ST_RETURN: state <= ST_RUN;
                default:   state <= ST_HALT;
            endcase
        end
    end

    assign bus.exc_take   = exc_take;
    assign bus.exc_vector = take_undef ? EXC_VEC_UNDEF : EXC_VEC_IRQ;
    assign bus.eret_take  = eret_take;
    assign bus.epc        = epc_q;
    assign bus.cause      = cause_q;
    assign bus.ker        = ker_q;
    assign bus.halt       = halt_q;

endmodule
